// File: rtl/system_reset_sequencer.sv
// system_reset_sequencer: turns the board/host reset into a staged pair of
// active-high resets. System reset releases first and CPU reset releases
// later. Debug-host requests can re-run the full sequence or restart only
// the cores while the debug fabric stays alive.
module system_reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int SYS_HOLD    = 16,
  parameter int CPU_DELAY   = 8,
  parameter int CPU_HOLD    = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sys_rst_req_i,
  input  logic cpu_rst_req_i,
  output logic rst_sys_o,
  output logic rst_cpu_o,
  output logic ready_o
);

  localparam int MAX_A = (SYS_HOLD > CPU_DELAY) ? SYS_HOLD : CPU_DELAY;
  localparam int MAX_N = (MAX_A > CPU_HOLD) ? MAX_A : CPU_HOLD;
  localparam int CW    = $clog2(MAX_N + 1);

  typedef enum logic [2:0] {
    S_SYNC,
    S_SYS,
    S_CPU,
    S_RUN,
    S_CPURST
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   rst_sys_q;
  logic                   rst_cpu_q;
  logic                   ready_q;

  // Deassertion synchronizer: clears asynchronously, shifts in ones after release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  // Sequencing FSM with registered outputs. A counter loaded with N expires
  // on the N-th following edge (leave when it reads 1). The synchronizer's
  // last stage is seen one edge late, so the power-up load of the system
  // hold is shortened by one to keep the release on edge SYNC_STAGES+SYS_HOLD.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_SYNC;
      cnt_q     <= '0;
      rst_sys_q <= 1'b1;
      rst_cpu_q <= 1'b1;
      ready_q   <= 1'b0;
    end else if (state_q != S_SYNC && sys_rst_req_i) begin
      // full system reset wins over everything, including a CPU request
      state_q   <= S_SYS;
      cnt_q     <= CW'(SYS_HOLD);
      rst_sys_q <= 1'b1;
      rst_cpu_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        S_SYNC: begin
          if (sync_q[SYNC_STAGES-1]) begin
            if (SYS_HOLD > 1) begin
              state_q <= S_SYS;
              cnt_q   <= CW'(SYS_HOLD - 1);
            end else if (CPU_DELAY > 0) begin
              state_q   <= S_CPU;
              cnt_q     <= CW'(CPU_DELAY);
              rst_sys_q <= 1'b0;
            end else begin
              state_q   <= S_RUN;
              rst_sys_q <= 1'b0;
              rst_cpu_q <= 1'b0;
              ready_q   <= 1'b1;
            end
          end
        end
        S_SYS: begin
          if (cnt_q == CW'(1)) begin
            if (CPU_DELAY > 0) begin
              state_q   <= S_CPU;
              cnt_q     <= CW'(CPU_DELAY);
              rst_sys_q <= 1'b0;
            end else begin
              state_q   <= S_RUN;
              rst_sys_q <= 1'b0;
              rst_cpu_q <= 1'b0;
              ready_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_CPU: begin
          if (cnt_q == CW'(1)) begin
            state_q   <= S_RUN;
            rst_cpu_q <= 1'b0;
            ready_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RUN: begin
          if (cpu_rst_req_i) begin
            state_q   <= S_CPURST;
            cnt_q     <= CW'(CPU_HOLD);
            rst_cpu_q <= 1'b1;
            ready_q   <= 1'b0;
          end
        end
        S_CPURST: begin
          if (cpu_rst_req_i) begin
            cnt_q <= CW'(CPU_HOLD);
          end else if (cnt_q == CW'(1)) begin
            state_q   <= S_RUN;
            rst_cpu_q <= 1'b0;
            ready_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q   <= S_SYNC;
          rst_sys_q <= 1'b1;
          rst_cpu_q <= 1'b1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rst_sys_o = rst_sys_q;
  assign rst_cpu_o = rst_cpu_q;
  assign ready_o   = ready_q;

endmodule

// File: tb/tb_system_reset_sequencer.sv
// Bench for system_reset_sequencer: expected {rst_sys,rst_cpu,ready} per edge
// are queued as stimulus is driven and popped one per clock by a monitor.
module tb_system_reset_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rst_n2 = 1'b1;
  logic sys_req = 1'b0;
  logic cpu_req = 1'b0;
  logic sys1, cpu1, rdy1;
  logic sys2, cpu2, rdy2;

  int    n_chk = 0;
  int    n_err = 0;
  string phase = "reset";
  logic [5:0] exp_q[$];
  logic [5:0] cur;

  always #5 clk = ~clk;

  system_reset_sequencer u_dut (
    .clk_i(clk), .rst_ni(rst_n), .sys_rst_req_i(sys_req), .cpu_rst_req_i(cpu_req),
    .rst_sys_o(sys1), .rst_cpu_o(cpu1), .ready_o(rdy1)
  );

  system_reset_sequencer #(.SYNC_STAGES(3), .SYS_HOLD(1), .CPU_DELAY(0), .CPU_HOLD(4)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n2), .sys_rst_req_i(sys_req), .cpu_rst_req_i(cpu_req),
    .rst_sys_o(sys2), .rst_cpu_o(cpu2), .ready_o(rdy2)
  );

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got sys/cpu/rdy=%b exp %b at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock: drive requests, queue expectation for the coming edge
  task automatic step(input logic s, input logic c, input logic [2:0] e1, input logic [2:0] e2);
    sys_req = s;
    cpu_req = c;
    exp_q.push_back({e1, e2});
    @(negedge clk);
  endtask

  // monitor: compare both instances shortly after each active edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk({phase, "/u1"}, {sys1, cpu1, rdy1}, cur[5:3]);
      chk({phase, "/u2"}, {sys2, cpu2, rdy2}, cur[2:0]);
    end
  end

  localparam logic [2:0] IN_RST = 3'b110;

  task automatic power_up();
    for (int e = 1; e <= 30; e++)
      step(1'b0, 1'b0, {e < 18, e < 26, e >= 26}, IN_RST);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    rst_n2 = 1'b0;
    #2;
    chk("rst_async/u1", {sys1, cpu1, rdy1}, IN_RST);
    chk("rst_async/u2", {sys2, cpu2, rdy2}, IN_RST);

    @(negedge clk);
    @(negedge clk);
    phase = "powerup";
    rst_n = 1'b1;
    power_up();

    phase = "cpu_pulse";
    for (int e = 0; e <= 6; e++)
      step(1'b0, e == 0, {1'b0, e < 4, e >= 4}, IN_RST);

    phase = "cpu_held";
    for (int e = 0; e <= 15; e++)
      step(1'b0, e <= 9, {1'b0, e < 13, e >= 13}, IN_RST);

    phase = "cpu_then_sys";
    for (int e = 0; e <= 28; e++)
      step(e == 2, e == 0, {e >= 2 && e < 18, e < 26, e >= 26}, IN_RST);

    phase = "sys_held";
    for (int e = 0; e <= 28; e++)
      step(e <= 2, e == 5 || e == 20, {e < 18, e < 26, e >= 26}, IN_RST);

    phase = "both_req";
    for (int e = 0; e <= 26; e++)
      step(e == 0, e == 0, {e < 16, e < 24, e >= 24}, IN_RST);

    phase = "mid_rst";
    for (int e = 0; e <= 19; e++)
      step(e == 0, 1'b0, {e < 16, e < 24, 1'b0}, IN_RST);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_async/u1", {sys1, cpu1, rdy1}, IN_RST);
    @(negedge clk);
    step(1'b0, 1'b0, IN_RST, IN_RST);
    step(1'b0, 1'b0, IN_RST, IN_RST);
    phase = "powerup2";
    rst_n = 1'b1;
    power_up();

    phase = "sweep";
    rst_n2 = 1'b1;
    for (int e = 1; e <= 8; e++)
      step(1'b0, 1'b0, 3'b001, (e < 4) ? IN_RST : 3'b001);

    repeat (3) @(negedge clk);
    chk("queue_drained", {2'b00, exp_q.size() != 0}, 3'b000);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
